instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Producer side of the decode interface: fetches instruction words from the icache and
//  hands {instruction, pc} to the control unit/decode stage over a valid/ready handshake.
//  Holds a DEPTH-entry prefetch FIFO, a fetch PC, redirect (branch/jump/jr) flush, and
//  stops fetching after a HALT opcode is queued. Sits between icache and control unit.
// PARAMETERS
//  DEPTH     4        FIFO entries; power of 2, >= 2
//  RESET_PC  32'h0    fetch PC loaded on reset
// PORTS
//  CLK          in   1                clock, all state on rising edge
//  RST          in   1                reset, asynchronous, active-high
//  iREN         out  1                icache read request
//  iaddr        out  32               icache word address (= fetch PC)
//  ihit         in   1                icache response valid for current iaddr
//  iload        in   32               icache response data
//  redirect     in   1                flush + refetch (taken branch, j, jal, jr)
//  redirect_pc  in   32               new fetch PC; bits [1:0] ignored (forced 0)
//  dec_valid    out  1                head entry valid for decode
//  dec_ready    in   1                decode accepts head entry
//  instruction  out  32               head instruction word
//  pc           out  32               address of head instruction
//  npc          out  32               pc + 4 (mod 2^32)
//  count        out  $clog2(DEPTH)+1  entries held
//  halt_seen    out  1                HALT (opcode 6'b111111) queued; fetch stopped
// BEHAVIOUR
//  - Reset (async, RST=1): fetch PC=RESET_PC, rd/wr ptrs=0, count=0, halt_seen=0;
//    dec_valid=0, iREN=0 while RST high; instruction/pc undefined-but-stable (drive 0).
//  - iREN = !RST & !full & !halt_seen. iaddr = fetch PC; iaddr held constant while
//    iREN=1 and ihit=0 (only redirect may change it).
//  - Push: iREN & ihit & !redirect -> write {iload, fetch PC} at wr ptr, wr ptr++,
//    fetch PC += 4 (wraps 32'hFFFFFFFC -> 0). If iload[31:26]==6'b111111 set halt_seen.
//  - Pop: dec_valid & dec_ready & !redirect -> rd ptr++. dec_valid = (count != 0).
//  - Push+pop same cycle: count unchanged, both ptrs advance. Ptrs wrap mod DEPTH.
//  - Full (count==DEPTH): iREN=0, no push; a pop that cycle frees a slot, iREN rises
//    next cycle. Empty: dec_valid=0, dec_ready ignored.
//  - Redirect (highest priority): next cycle count=0, ptrs=0, halt_seen=0,
//    fetch PC={redirect_pc[31:2],2'b00}; concurrent ihit data and pop discarded.
//    iREN may be high the same cycle with old iaddr; cache result is dropped.
//  - Latency: ihit at cycle N -> dec_valid at N+1 with that word (non-bypass).
//  - Order: entries leave strictly in fetch order; pc of consecutive entries differs by 4.
//  - halt_seen holds until redirect or reset; queued entries still drain normally.
//  - RST asserted mid-fetch: all state clears immediately; no partial push survives.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: when count==0 and iREN&ihit&!redirect, dec_valid=1 same
//    cycle with instruction=iload, pc=iaddr; if dec_ready also 1 the word is not stored
//    (count stays 0, PC still advances, HALT still sets halt_seen). Zero-cycle latency.
//  FETCH_BYPASS_EN undefined: no combinational path ihit/iload -> dec_* ; min latency 1.
// TESTING
//  1 Reset, RESET_PC=0, ihit=1 every cycle, dec_ready=1 -> pc sequence 0,4,8,12...,
//    dec_valid from cycle 2 (cycle 1 with FETCH_BYPASS_EN), count stays <= 1.
//  2 dec_ready=0, ihit=1 -> count 1..4, iREN=0 at count=4, iaddr frozen at 0x10;
//    raise dec_ready 1 cycle -> iREN=1 next cycle, fetch of 0x10 completes.
//  3 Fill 3 entries, assert redirect with redirect_pc=0x403 and ihit same cycle ->
//    next cycle count=0, iaddr=0x400, first popped pc=0x400, old ihit data absent.
//  4 iload=0xFC000000 at pc 0x8 -> halt_seen=1, iREN=0 after; entries 0,4,8 drain,
//    then dec_valid=0; redirect to 0x0 clears halt_seen, fetching resumes.
//  5 redirect_pc=0xFFFFFFF8, ihit every cycle -> pcs FFFFFFF8, FFFFFFFC, 0, 4; npc wraps.
//  6 Assert RST mid-burst (count=2, iREN=1) -> count=0, dec_valid=0, iREN=0
//    immediately; after release iaddr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: icache request/response, redirect and decode handshake.
// The master modport is the fetch queue; the slave modport is the icache/decode side.
interface instr_fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     iREN;
  logic [31:0]              iaddr;
  logic                     ihit;
  logic [31:0]              iload;
  logic                     redirect;
  logic [31:0]              redirect_pc;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [31:0]              instruction;
  logic [31:0]              pc;
  logic [31:0]              npc;
  logic [$clog2(DEPTH):0]   count;
  logic                     halt_seen;

  modport master (
    output iREN, iaddr, dec_valid, instruction, pc, npc, count, halt_seen,
    input  ihit, iload, redirect, redirect_pc, dec_ready
  );

  modport slave (
    input  iREN, iaddr, dec_valid, instruction, pc, npc, count, halt_seen,
    output ihit, iload, redirect, redirect_pc, dec_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch FIFO between icache and decode, with redirect flush and HALT stop.
// Optional macro FETCH_BYPASS_EN: an icache hit into an empty queue is offered to decode the same cycle.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                  CLK,
  input logic                  RST,
  instr_fetch_queue_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_instr_r [DEPTH];
  logic [31:0]   mem_pc_r    [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   fetch_pc_r;
  logic          halt_r;

  logic          full_s;
  logic          iren_s;
  logic          push_s;
  logic          store_s;
  logic          pop_s;
  logic [31:0]   redirect_target_s;
  logic          dec_valid_s;
  logic [31:0]   head_instr_s;
  logic [31:0]   head_pc_s;

  function automatic logic is_halt(input logic [31:0] word);
    return (word[31:26] == 6'b111111);
  endfunction

  // Fetch request, push/pop qualification and redirect target
  always_comb begin
    full_s            = (count_r == CW'(DEPTH));
    iren_s            = !RST && !full_s && !halt_r;
    push_s            = iren_s && bus.ihit && !bus.redirect;
    pop_s             = (count_r != {CW{1'b0}}) && bus.dec_ready && !bus.redirect;
    redirect_target_s = bus.redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_BYPASS_EN
    // A word handed straight to decode from an empty queue is never stored.
    if ((count_r == {CW{1'b0}}) && push_s && bus.dec_ready) begin
      store_s = 1'b0;
    end else begin
      store_s = push_s;
    end
`else
    store_s = push_s;
`endif
  end

  // Queue storage, pointers, occupancy, fetch PC and HALT tracking
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_r[i] <= 32'h0000_0000;
        mem_pc_r[i]    <= 32'h0000_0000;
      end
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      fetch_pc_r <= RESET_PC;
      halt_r     <= 1'b0;
    end else if (bus.redirect) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      fetch_pc_r <= redirect_target_s;
      halt_r     <= 1'b0;
    end else begin
      if (store_s) begin
        mem_instr_r[wr_ptr_r] <= bus.iload;
        mem_pc_r[wr_ptr_r]    <= fetch_pc_r;
        wr_ptr_r              <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({store_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (push_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
        if (is_halt(bus.iload)) begin
          halt_r <= 1'b1;
        end
      end
    end
  end

  // Decode-side head selection
  always_comb begin
`ifdef FETCH_BYPASS_EN
    if ((count_r == {CW{1'b0}}) && push_s) begin
      dec_valid_s  = 1'b1;
      head_instr_s = bus.iload;
      head_pc_s    = fetch_pc_r;
    end else begin
      dec_valid_s  = (count_r != {CW{1'b0}});
      head_instr_s = mem_instr_r[rd_ptr_r];
      head_pc_s    = mem_pc_r[rd_ptr_r];
    end
`else
    dec_valid_s  = (count_r != {CW{1'b0}});
    head_instr_s = mem_instr_r[rd_ptr_r];
    head_pc_s    = mem_pc_r[rd_ptr_r];
`endif
  end

  assign bus.iREN        = iren_s;
  assign bus.iaddr       = fetch_pc_r;
  assign bus.dec_valid   = dec_valid_s;
  assign bus.instruction = head_instr_s;
  assign bus.pc          = head_pc_s;
  assign bus.npc         = head_pc_s + 32'd4;
  assign bus.count       = count_r;
  assign bus.halt_seen   = halt_r;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: a queue-based reference model predicts every
// observable output each cycle, including redirect, HALT, full-stall and mid-run resets.
module tb_instr_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  instr_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int          vec_count = 0;
  int          err_count = 0;
  logic [63:0] model_q [$];
  logic [31:0] model_pc;
  logic        model_halt;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: observed %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_iren();
    return !model_halt && (model_q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    model_q.delete();
    model_pc   = RESET_PC;
    model_halt = 1'b0;
  endtask

  task automatic check_outputs();
    logic [31:0] head_instr;
    logic [31:0] head_pc;
    check_value("iREN",      {31'd0, bus.iREN},      {31'd0, model_iren()});
    check_value("iaddr",     bus.iaddr,              model_pc);
    check_value("count",     32'(bus.count),         32'(model_q.size()));
    check_value("halt_seen", {31'd0, bus.halt_seen}, {31'd0, model_halt});
    check_value("dec_valid", {31'd0, bus.dec_valid}, {31'd0, (model_q.size() != 0)});
    if (model_q.size() != 0) begin
      head_instr = model_q[0][63:32];
      head_pc    = model_q[0][31:0];
      check_value("instruction", bus.instruction, head_instr);
      check_value("pc",          bus.pc,          head_pc);
      check_value("npc",         bus.npc,         head_pc + 32'd4);
    end
  endtask

  // Apply one clock edge's worth of behaviour to the reference model.
  task automatic advance_model();
    logic do_push;
    logic do_pop;
    if (bus.redirect) begin
      model_q.delete();
      model_halt = 1'b0;
      model_pc   = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      do_push = model_iren() && bus.ihit;
      do_pop  = (model_q.size() != 0) && bus.dec_ready;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back({bus.iload, model_pc});
        if (bus.iload[31:26] == 6'b111111) model_halt = 1'b1;
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  function automatic logic [31:0] rand_word(input int halt_pct);
    logic [31:0] w;
    w = $urandom;
    if (int'($urandom_range(99)) < halt_pct) w[31:26] = 6'b111111;
    else if (w[31:26] == 6'b111111) w[31] = 1'b0;
    return w;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] low;
    low = 32'($urandom_range(3));
    case ($urandom_range(3))
      0:       return 32'hFFFF_FFF8 | low;
      1:       return 32'h0000_0403;
      2:       return 32'h0000_0000 | low;
      default: return $urandom;
    endcase
  endfunction

  int ready_pct [4] = '{90, 10, 50, 60};
  int hit_pct   [4] = '{95, 90, 50, 80};
  int redir_pct [4] = '{2, 1, 4, 2};
  int halt_pct  [4] = '{0, 3, 6, 3};

  initial begin
    bus.ihit        = 1'b0;
    bus.iload       = 32'h0000_0000;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0000_0000;
    bus.dec_ready   = 1'b0;
    model_reset();

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_value("rst_iREN",        {31'd0, bus.iREN},      32'd0);
    check_value("rst_dec_valid",   {31'd0, bus.dec_valid}, 32'd0);
    check_value("rst_count",       32'(bus.count),         32'd0);
    check_value("rst_halt_seen",   {31'd0, bus.halt_seen}, 32'd0);
    check_value("rst_instruction", bus.instruction,        32'd0);
    check_value("rst_pc",          bus.pc,                 32'd0);
    check_value("rst_iaddr",       bus.iaddr,              RESET_PC);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      int ph;
      ph = cyc / 1000;
      @(posedge CLK);
      #1;
      RST             = (cyc > 20) && ($urandom_range(999) < 4);
      bus.ihit        = (int'($urandom_range(99)) < hit_pct[ph]);
      bus.iload       = rand_word(halt_pct[ph]);
      bus.redirect    = (int'($urandom_range(99)) < redir_pct[ph]);
      bus.redirect_pc = rand_target();
      bus.dec_ready   = (int'($urandom_range(99)) < ready_pct[ph]);
      @(negedge CLK);
      if (RST) begin
        check_value("mid_rst_iREN",      {31'd0, bus.iREN},      32'd0);
        check_value("mid_rst_dec_valid", {31'd0, bus.dec_valid}, 32'd0);
        check_value("mid_rst_count",     32'(bus.count),         32'd0);
        check_value("mid_rst_halt_seen", {31'd0, bus.halt_seen}, 32'd0);
        model_reset();
      end else begin
        check_outputs();
        advance_model();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
